// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants, output-mode encoding and helper functions
//               for the 16-channel PWM output stage.
//               Contents:
//                 PWM_CNT_MAX  last value of the 8-bit period counter
//                 DUTY_FULL    duty value that forces a constant-high wave
//                 N_OUT        number of output pins
//                 out_mode_e   per-pin drive mode (off / static / pwm)
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam logic [7:0] PWM_CNT_MAX = 8'd254;
    localparam logic [7:0] DUTY_FULL   = 8'hFF;
    localparam int         N_OUT       = 16;

    // Per-pin drive mode, decoded from the enable and PWM-select bits
    typedef enum logic [1:0] {
        OUT_MODE_OFF    = 2'd0,
        OUT_MODE_STATIC = 2'd1,
        OUT_MODE_PWM    = 2'd2
    } out_mode_e;

    // The enable bit dominates: a disabled pin is low whatever its PWM select
    function automatic out_mode_e out_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return OUT_MODE_OFF;
        end else if (en_pwm) begin
            return OUT_MODE_PWM;
        end else begin
            return OUT_MODE_STATIC;
        end
    endfunction

    // Prescaler width; a divide-by-1 prescaler still keeps a 1-bit counter
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_peripheral_if
// Description : Configuration and pin bundle of the PWM output stage.
//               master : drives the five configuration registers, observes pins
//               slave  : the output stage itself
//               Signals:
//                 en_reg_out_7_0 / en_reg_out_15_8  [7:0] output enables
//                 en_reg_pwm_7_0 / en_reg_pwm_15_8  [7:0] PWM-mode selects
//                 pwm_duty_cycle                    [7:0] duty in 1/255 units
//                 out                               [15:0] registered pins
//                 period_start                      first-cycle-of-period pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_peripheral_if;
    import pwm_pkg::*;

    logic [7:0]       en_reg_out_7_0;
    logic [7:0]       en_reg_out_15_8;
    logic [7:0]       en_reg_pwm_7_0;
    logic [7:0]       en_reg_pwm_15_8;
    logic [7:0]       pwm_duty_cycle;
    logic [N_OUT-1:0] out;
    logic             period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );

endinterface
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : Prescaler plus 8-bit period counter shared by all PWM pins.
//               The period counter runs 0..254 so one PWM period spans
//               255 prescaler ticks.
//               Ports:
//                 clk       system clock
//                 rst       synchronous active-high reset
//                 pwm_cnt   [7:0] position inside the current period
//                 tick      prescaler terminal count (counter advances)
//                 boundary  tick on the last count of a period
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  wire logic       clk,
    input  wire logic       rst,
    output logic [7:0]      pwm_cnt,
    output logic            tick,
    output logic            boundary
);

    localparam int                  c_presc_w   = presc_width(CLK_DIV);
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_DIV - 1);

    logic [c_presc_w-1:0] r_presc_cnt_q;
    logic [c_presc_w-1:0] w_presc_cnt_d;
    logic [7:0]           r_pwm_cnt_q;
    logic [7:0]           w_pwm_cnt_d;
    logic                 w_tick;
    logic                 w_boundary;

    // With CLK_DIV == 1 the max is 0, so the counter sits at 0 and ticks
    // every cycle.
    always_comb begin
        w_tick        = (r_presc_cnt_q == c_presc_max);
        w_boundary    = w_tick && (r_pwm_cnt_q == PWM_CNT_MAX);
        w_presc_cnt_d = w_tick ? '0 : r_presc_cnt_q + 1'b1;
        w_pwm_cnt_d   = r_pwm_cnt_q;
        if (w_tick) begin
            w_pwm_cnt_d = (r_pwm_cnt_q == PWM_CNT_MAX) ? 8'd0 : r_pwm_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc_cnt_q <= '0;
            r_pwm_cnt_q   <= 8'd0;
        end else begin
            r_presc_cnt_q <= w_presc_cnt_d;
            r_pwm_cnt_q   <= w_pwm_cnt_d;
        end
    end

    assign pwm_cnt  = r_pwm_cnt_q;
    assign tick     = w_tick;
    assign boundary = w_boundary;

endmodule
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : pwm_peripheral
// Description : 16-pin output stage. Each pin is forced low, driven static
//               high, or follows a shared PWM waveform. The duty cycle is
//               shadowed and only updated at period boundaries so a running
//               waveform never glitches.
//               Ports:
//                 clk   system clock
//                 rst   synchronous active-high reset
//                 bus   pwm_peripheral_if.slave (config registers in,
//                       out[15:0] and period_start out)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pwm_peripheral_if.slave  bus
);

    logic [7:0]       w_pwm_cnt;
    logic             w_tick;
    logic             w_boundary;
    logic             w_duty_load;

    logic [N_OUT-1:0] w_en_out;
    logic [N_OUT-1:0] w_en_pwm;
    out_mode_e        w_mode [N_OUT];

    logic [7:0]       r_duty_sh_q;
    logic [7:0]       w_duty_sh_d;
    logic             w_pwm_sig;
    logic [N_OUT-1:0] r_out_q;
    logic [N_OUT-1:0] w_out_d;
    logic             r_period_start_q;
    logic             w_period_start_d;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .pwm_cnt  (w_pwm_cnt),
        .tick     (w_tick),
        .boundary (w_boundary)
    );

    assign w_en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign w_en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // boundary already implies tick; qualifying with tick keeps the shadow
    // load tied to a prescaler edge by construction.
    assign w_duty_load = w_tick && w_boundary;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out_mode
            assign w_mode[gi] = out_mode(w_en_out[gi], w_en_pwm[gi]);
        end
    endgenerate

    always_comb begin
        // The duty written on the boundary cycle itself is the one captured
        w_duty_sh_d      = w_duty_load ? bus.pwm_duty_cycle : r_duty_sh_q;
        // 255 must be solid high: the counter never reaches 255, so a plain
        // compare would leave one low step per period.
        w_pwm_sig        = (r_duty_sh_q == DUTY_FULL) || (w_pwm_cnt < r_duty_sh_q);
        w_period_start_d = w_boundary;
        w_out_d          = '0;
        for (int i = 0; i < N_OUT; i++) begin
            case (w_mode[i])
                OUT_MODE_STATIC: w_out_d[i] = 1'b1;
                OUT_MODE_PWM:    w_out_d[i] = w_pwm_sig;
                default:         w_out_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_sh_q      <= 8'd0;
            r_out_q          <= '0;
            r_period_start_q <= 1'b0;
        end else begin
            r_duty_sh_q      <= w_duty_sh_d;
            r_out_q          <= w_out_d;
            r_period_start_q <= w_period_start_d;
        end
    end

    assign bus.out          = r_out_q;
    assign bus.period_start = r_period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_peripheral
// Description : Directed self-checking bench for pwm_peripheral, CLK_DIV = 2
//               (510-clock PWM period).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_peripheral;
    import pwm_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 255 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_peripheral_if u_if ();

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // one rising edge, then sample point on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        u_if.en_reg_out_7_0  = eo[7:0];
        u_if.en_reg_out_15_8 = eo[15:8];
        u_if.en_reg_pwm_7_0  = ep[7:0];
        u_if.en_reg_pwm_15_8 = ep[15:8];
    endtask

    // Waits (bounded) until period_start is seen at a sample point
    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (u_if.period_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Starting at the sample point where period_start is high, runs one full
    // period. Counts out[0] highs over offsets 1..PERIOD, optionally changes the
    // duty register after the sample at offset change_off, and reports whether
    // period_start showed up exactly at offset PERIOD and nowhere before.
    bit trace [PERIOD+1];
    task automatic run_period(input int change_off, input logic [7:0] nd,
                              output int highs, output bit ps_ok);
        highs = 0;
        ps_ok = 1'b1;
        for (int off = 1; off <= PERIOD; off++) begin
            step();
            trace[off] = u_if.out[0];
            if (u_if.out[0]) highs++;
            if (off < PERIOD && u_if.period_start) ps_ok = 1'b0;
            if (off == PERIOD && !u_if.period_start) ps_ok = 1'b0;
            if (off == change_off) u_if.pwm_duty_cycle = nd;
        end
    endtask

    // Entered at the sample point right after the reset edge(s), with rst
    // already released: first period low, first pulse 510 clocks later,
    // programmed duty visible one clock after that pulse.
    task automatic check_first_period(input string tag, input logic [15:0] exp_after);
        int  first_ps;
        bit  low_ok;
        logic [15:0] out_after;
        first_ps  = -1;
        low_ok    = 1'b1;
        out_after = '0;
        for (int k = 1; k <= PERIOD + 1; k++) begin
            step();
            if (k <= PERIOD && u_if.out !== 16'h0000) low_ok = 1'b0;
            if (u_if.period_start === 1'b1 && first_ps < 0) first_ps = k;
            if (k == PERIOD + 1) out_after = u_if.out;
        end
        checks++;
        if (!low_ok) begin
            errors++;
            $display("FAIL %s_first_period_low: out was nonzero, required 0 for %0d clocks", tag, PERIOD);
        end
        checks++;
        if (first_ps != PERIOD) begin
            errors++;
            $display("FAIL %s_first_period_start: got clock %0d, required %0d", tag, first_ps, PERIOD);
        end
        checks++;
        if (out_after !== exp_after) begin
            errors++;
            $display("FAIL %s_second_period_out: got %h, required %h", tag, out_after, exp_after);
        end
    endtask

    task automatic test_reset();
        u_if.pwm_duty_cycle = 8'h80;
        set_en(16'hFFFF, 16'hFFFF);
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (u_if.out !== 16'h0000 || u_if.period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: out=%h ps=%b, required out=0000 ps=0",
                     u_if.out, u_if.period_start);
        end
        rst = 1'b0;
        check_first_period("reset", 16'hFFFF);
    endtask

    // Entry: just after the sample point one clock past the first pulse
    task automatic test_half_duty();
        bit ok;
        int highs;
        bit ps_ok;
        set_en(16'h0001, 16'h0001);
        wait_ps(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL half_wait_period_start: got timeout, required pulse");
        end
        checks++;
        if (u_if.out[0] !== 1'b0) begin
            errors++;
            $display("FAIL half_low_at_pulse: got %b, required 0", u_if.out[0]);
        end
        run_period(-1, 8'h00, highs, ps_ok);
        checks++;
        if (highs != 256) begin
            errors++;
            $display("FAIL half_high_time: got %0d, required 256", highs);
        end
        checks++;
        if (trace[1] !== 1'b1 || trace[256] !== 1'b1 || trace[257] !== 1'b0) begin
            errors++;
            $display("FAIL half_edges: got off1=%b off256=%b off257=%b, required 1 1 0",
                     trace[1], trace[256], trace[257]);
        end
        checks++;
        if (!ps_ok) begin
            errors++;
            $display("FAIL half_period_length: got misplaced pulse, required pulse at %0d", PERIOD);
        end
    endtask

    // Entry: at a pulse sample point, duty_sh = 0x80
    task automatic test_extremes();
        int highs;
        bit ps_ok;
        u_if.pwm_duty_cycle = 8'h00;
        run_period(-1, 8'h00, highs, ps_ok);
        checks++;
        if (highs != 256) begin
            errors++;
            $display("FAIL shadow_holds_old_duty: got %0d, required 256", highs);
        end
        for (int p = 0; p < 3; p++) begin
            run_period(-1, 8'h00, highs, ps_ok);
            checks++;
            if (highs != 0 || !ps_ok) begin
                errors++;
                $display("FAIL duty00_period%0d: got highs=%0d ps_ok=%b, required 0 1", p, highs, ps_ok);
            end
        end
        u_if.pwm_duty_cycle = 8'hFF;
        run_period(-1, 8'h00, highs, ps_ok);
        for (int p = 0; p < 3; p++) begin
            run_period(-1, 8'h00, highs, ps_ok);
            checks++;
            if (highs != PERIOD || !ps_ok) begin
                errors++;
                $display("FAIL dutyFF_period%0d: got highs=%0d ps_ok=%b, required %0d 1",
                         p, highs, ps_ok, PERIOD);
            end
        end
    endtask

    // duty_sh = 0xFF on entry
    task automatic test_static_modes();
        set_en(16'hA5A5, 16'h0000);
        step();
        checks++;
        if (u_if.out !== 16'hA5A5) begin
            errors++;
            $display("FAIL static_a5a5: got %h, required a5a5", u_if.out);
        end
        set_en(16'h0000, 16'hFFFF);
        step();
        checks++;
        if (u_if.out !== 16'h0000) begin
            errors++;
            $display("FAIL static_disabled_pwm: got %h, required 0000", u_if.out);
        end
        set_en(16'hFFFF, 16'h0F0F);
        step();
        checks++;
        if (u_if.out !== 16'hFFFF) begin
            errors++;
            $display("FAIL static_mixed_full_duty: got %h, required ffff", u_if.out);
        end
        set_en(16'h3C00, 16'h0000);
        step();
        checks++;
        if (u_if.out !== 16'h3C00) begin
            errors++;
            $display("FAIL static_upper_byte: got %h, required 3c00", u_if.out);
        end
    endtask

    task automatic test_glitch_free_update();
        bit ok;
        int highs;
        bit ps_ok;
        set_en(16'h0001, 16'h0001);
        u_if.pwm_duty_cycle = 8'h40;
        wait_ps(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL glitch_wait_period_start: got timeout, required pulse");
        end
        // pwm_cnt == 0x10 during offsets 32 and 33
        run_period(32, 8'hC0, highs, ps_ok);
        checks++;
        if (highs != 128 || !ps_ok) begin
            errors++;
            $display("FAIL glitch_current_period: got highs=%0d ps_ok=%b, required 128 1", highs, ps_ok);
        end
        // offset 509 is the boundary cycle: change lands inside it
        run_period(509, 8'h20, highs, ps_ok);
        checks++;
        if (highs != 384 || !ps_ok) begin
            errors++;
            $display("FAIL glitch_next_period: got highs=%0d ps_ok=%b, required 384 1", highs, ps_ok);
        end
        run_period(300, 8'h80, highs, ps_ok);
        checks++;
        if (highs != 64 || !ps_ok) begin
            errors++;
            $display("FAIL glitch_boundary_capture: got highs=%0d ps_ok=%b, required 64 1", highs, ps_ok);
        end
    endtask

    // Entry: at a pulse sample point with duty_sh = 0x80
    task automatic test_mid_reset();
        for (int off = 1; off <= 160; off++) step();
        checks++;
        if (u_if.out !== 16'h0001) begin
            errors++;
            $display("FAIL midreset_pre_high: got %h, required 0001", u_if.out);
        end
        rst = 1'b1;
        step();
        checks++;
        if (u_if.out !== 16'h0000 || u_if.period_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: out=%h ps=%b, required out=0000 ps=0",
                     u_if.out, u_if.period_start);
        end
        rst = 1'b0;
        check_first_period("midreset", 16'h0001);
    endtask

    initial begin
        u_if.pwm_duty_cycle = 8'h00;
        set_en(16'h0000, 16'h0000);
        @(negedge clk);
        test_reset();
        test_half_duty();
        test_extremes();
        test_static_modes();
        test_glitch_free_update();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_peripheral.md
# pwm_peripheral

Output stage that consumes the five configuration registers written over SPI (`en_reg_out_7_0`, `en_reg_out_15_8`, `en_reg_pwm_7_0`, `en_reg_pwm_15_8`, `pwm_duty_cycle`) and drives 16 registered outputs. Each output is forced low, driven static high, or driven by a shared PWM waveform. The duty cycle is shadowed and updated only at period boundaries, so waveforms are glitch-free.

## Interface
- `CLK_DIV`, default 13: prescaler divide ratio, ≥1. PWM frequency = f_clk / (255·CLK_DIV), which is about 3.02 kHz at 10 MHz.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `en_reg_out_7_0`  in  8  output enable, bits 7:0.
- `en_reg_out_15_8`  in  8  output enable, bits 15:8.
- `en_reg_pwm_7_0`  in  8  PWM-mode select, bits 7:0.
- `en_reg_pwm_15_8`  in  8  PWM-mode select, bits 15:8.
- `pwm_duty_cycle`  in  8  requested duty, in units of 1/255.
- `out`  out  16  registered output pins.
- `period_start`  out  1  one-cycle pulse marking the first cycle of each PWM period.

## Operation
- Prescaler `presc_cnt`, width $clog2(CLK_DIV) (min 1):
  - Counts 0..CLK_DIV-1 and wraps.
  - `tick` = (presc_cnt == CLK_DIV-1).
  - With CLK_DIV=1, tick is high every cycle.
- Period counter `pwm_cnt`, 8 bits:
  - Advances on tick, 0..254, wraps 254→0. Value 255 is never reached.
  - `boundary` = tick && pwm_cnt == 254.
- Duty shadow `duty_sh`:
  - Loads `pwm_duty_cycle` on the edge where boundary is high. No other edge loads it.
  - If pwm_duty_cycle changes in the same cycle as boundary, the new value is captured.
- `pwm_sig` = (duty_sh == 8'hFF) || (pwm_cnt < duty_sh), unsigned compare.
  - duty 0: never high.
  - duty 255: always high.
  - duty d in 1..254: high for d·CLK_DIV clocks per 255·CLK_DIV-clock period.
- Output mux, per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - out[i] <= en_out[i] & (~en_pwm[i] | pwm_sig).
  - en_out=0 gives 0 regardless of en_pwm.
  - en_out=1, en_pwm=0 gives 1.
  - en_out=1, en_pwm=1 gives pwm_sig.
- Enable changes take effect on the next edge. They are not period-aligned.
- `period_start` <= boundary.

## Timing
- Reset values: out=16'h0000, period_start=0, presc_cnt=0, pwm_cnt=0, duty_sh=0.
- Reset mid-operation: all state clears on the first rising edge with rst=1. Outputs stay at reset values while rst is high.
- The first period after reset has duty_sh=0, so PWM-mode outputs are low. The programmed duty applies from the second period, starting 255·CLK_DIV clocks after reset release.
- Latency:
  - Inputs to out: 1 clock.
  - pwm_cnt to out: 1 clock.
- period_start is high during the first cycle with pwm_cnt==0 of a new period. out reflects that period from the following cycle.
- No handshake. Inputs are sampled every cycle and are assumed stable, i.e. already synchronous to clk.

## Structure
- Package `pwm_pkg` holds:
  - `PWM_CNT_MAX` = 8'd254.
  - `DUTY_FULL` = 8'hFF.
  - `N_OUT` = 16.
- Sub-module `pwm_timebase`, parameter CLK_DIV:
  - Contains the prescaler and period counter.
  - Outputs pwm_cnt[7:0], tick, boundary.
- The top level holds duty_sh, the compare, the output mux/register and period_start.

## Test plan
All scenarios use CLK_DIV=2 (period = 510 clocks).
- **Reset behaviour:** duty=0x80, all enable regs 0xFF, rst high 3 cycles, then low.
  - out==0 and period_start==0 during reset.
  - out==0 for the first 510 clocks.
  - First period_start pulse 510 clocks after release.
- **Half duty:** duty=0x80, en_out[0]=1, en_pwm[0]=1, from the second period on.
  - out[0] high exactly 256 clocks, low 254, per period.
  - The rising edge of out[0] is 1 cycle after period_start.
- **Extremes:**
  - duty=0x00: out[0] never high across 3 periods.
  - duty=0xFF: out[0] continuously high across 3 periods, including across boundaries.
- **Static modes:**
  - en_out=16'hA5A5, en_pwm=0: out==16'hA5A5 one clock later.
  - Then en_out=0, en_pwm=16'hFFFF: out==0 one clock later.
- **Glitch-free update:** duty=0x40 running; change to 0xC0 when pwm_cnt==0x10.
  - Current period high time stays 128 clocks.
  - Next period high time is 384 clocks.
  - A change coincident with boundary applies immediately.
- **Mid-period reset:** rst pulsed 1 cycle at pwm_cnt==0x50 with out[0] high.
  - out==0 on the next edge.
  - Counters restart; first-period-low behaviour repeats.
